// File: rtl/tpu_pkg.sv
// Shared TPU definitions: operand width, operand store address map, feed length
// and the control-unit state encoding that this datapath is driven by.
package tpu_pkg;

  localparam int DATA_W          = 8;
  localparam int NUM_ADDR        = 8;
  localparam int FEED_LAST_CYCLE = 5;

  localparam logic [2:0] ADDR_A00 = 3'd0;
  localparam logic [2:0] ADDR_A01 = 3'd1;
  localparam logic [2:0] ADDR_A10 = 3'd2;
  localparam logic [2:0] ADDR_A11 = 3'd3;
  localparam logic [2:0] ADDR_B00 = 3'd4;
  localparam logic [2:0] ADDR_B01 = 3'd5;
  localparam logic [2:0] ADDR_B10 = 3'd6;
  localparam logic [2:0] ADDR_B11 = 3'd7;

  typedef enum logic [1:0] {
    CU_IDLE      = 2'd0,
    CU_LOAD_MATS = 2'd1,
    CU_FEED      = 2'd2
  } cu_state_e;

endpackage

// File: rtl/operand_store.sv
// Eight-entry operand register file with per-address written flags and a sticky
// flag for writes that collide with an active feed phase.
module operand_store #(
  parameter int DATA_W = tpu_pkg::DATA_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_load_en,
  input  logic [2:0]                               i_load_addr,
  input  logic [DATA_W-1:0]                        i_data,
  input  logic                                     i_feed_en,
  input  logic                                     i_mask_clr,
  output logic [tpu_pkg::NUM_ADDR-1:0][DATA_W-1:0] o_mem,
  output logic [tpu_pkg::NUM_ADDR-1:0]             o_mask,
  output logic                                     o_err_overlap
);
  import tpu_pkg::*;

  logic [NUM_ADDR-1:0][DATA_W-1:0] r_mem;
  logic [NUM_ADDR-1:0]             r_mask;
  logic                            r_err;

  // Feed owns the store: a concurrent write is dropped and only flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_mask <= '0;
      r_err  <= 1'b0;
    end else if (i_feed_en) begin
      if (i_load_en)  r_err  <= 1'b1;
      if (i_mask_clr) r_mask <= '0;
    end else if (i_load_en) begin
      r_mem[i_load_addr]  <= i_data;
      r_mask[i_load_addr] <= 1'b1;
    end
  end

  assign o_mem         = r_mem;
  assign o_mask        = r_mask;
  assign o_err_overlap = r_err;

endmodule

// File: rtl/operand_skew_feeder.sv
// Operand store plus the diagonal skew schedule that feeds A rows and B columns
// into the 2x2 systolic MMU edges, one registered cycle after feed_cycle.
module operand_skew_feeder #(
  parameter int DATA_W     = tpu_pkg::DATA_W,
  parameter int LAST_CYCLE = tpu_pkg::FEED_LAST_CYCLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              feed_en,
  input  logic [2:0]        feed_cycle,
  output logic [DATA_W-1:0] a_in0,
  output logic [DATA_W-1:0] a_in1,
  output logic [DATA_W-1:0] b_in0,
  output logic [DATA_W-1:0] b_in1,
  output logic              feed_valid,
  output logic [7:0]        written_mask,
  output logic              store_full,
  output logic              err_overlap
);
  import tpu_pkg::*;

  logic [NUM_ADDR-1:0][DATA_W-1:0] w_mem;
  logic                            w_mask_clr;
  logic [DATA_W-1:0]               r_a0, r_a1, r_b0, r_b1;
  logic                            r_valid;

  assign w_mask_clr = feed_en && (feed_cycle == 3'(LAST_CYCLE));

  operand_store #(.DATA_W(DATA_W)) u_store (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load_en     (load_en),
    .i_load_addr   (load_addr),
    .i_data        (data_in),
    .i_feed_en     (feed_en),
    .i_mask_clr    (w_mask_clr),
    .o_mem         (w_mem),
    .o_mask        (written_mask),
    .o_err_overlap (err_overlap)
  );

  // Zeros are driven outside the three schedule cycles so the array flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a0    <= '0;
      r_a1    <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_a0    <= '0;
      r_a1    <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
      r_valid <= 1'b0;
      if (feed_en) begin
        case (feed_cycle)
          3'd0: begin
            r_a0    <= w_mem[ADDR_A00];
            r_b0    <= w_mem[ADDR_B00];
            r_valid <= 1'b1;
          end
          3'd1: begin
            r_a0    <= w_mem[ADDR_A01];
            r_a1    <= w_mem[ADDR_A10];
            r_b0    <= w_mem[ADDR_B10];
            r_b1    <= w_mem[ADDR_B01];
            r_valid <= 1'b1;
          end
          3'd2: begin
            r_a1    <= w_mem[ADDR_A11];
            r_b1    <= w_mem[ADDR_B11];
            r_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign a_in0      = r_a0;
  assign a_in1      = r_a1;
  assign b_in0      = r_b0;
  assign b_in1      = r_b1;
  assign feed_valid = r_valid;
  assign store_full = &written_mask;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Self-checking bench for operand_skew_feeder: a directed vector table, hand-written
// corner sequences and a randomized run against a matrix-level reference model.
module tb_operand_skew_feeder;

  localparam int LAST = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [2:0] load_addr;
  logic [7:0] data_in;
  logic       feed_en;
  logic [2:0] feed_cycle;
  logic [7:0] a_in0, a_in1, b_in0, b_in1;
  logic       feed_valid;
  logic [7:0] written_mask;
  logic       store_full;
  logic       err_overlap;

  int errors = 0;
  int checks = 0;

  logic [7:0] mMem [8];
  logic [7:0] mMask;
  logic       mErr;
  logic [7:0] mA0, mA1, mB0, mB1;
  logic       mValid;

  typedef struct {
    logic       le;
    logic [2:0] la;
    logic [7:0] din;
    logic       fe;
    logic [2:0] fc;
    logic [7:0] ea0, ea1, eb0, eb1;
    logic       ev;
    logic [7:0] emask;
  } vec_t;

  vec_t tbl [15];

  operand_skew_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .data_in      (data_in),
    .feed_en      (feed_en),
    .feed_cycle   (feed_cycle),
    .a_in0        (a_in0),
    .a_in1        (a_in1),
    .b_in0        (b_in0),
    .b_in1        (b_in1),
    .feed_valid   (feed_valid),
    .written_mask (written_mask),
    .store_full   (store_full),
    .err_overlap  (err_overlap)
  );

  always #5 clk = ~clk;

  // A is row-major at 0..3, B row-major at 4..7; element k of row/col i enters at cycle i+k.
  function automatic logic [7:0] aRef(int row, int c);
    int k = c - row;
    if (k < 0 || k > 1) return 8'h00;
    return mMem[row*2 + k];
  endfunction

  function automatic logic [7:0] bRef(int col, int c);
    int k = c - col;
    if (k < 0 || k > 1) return 8'h00;
    return mMem[4 + k*2 + col];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mMem[i] = 8'h00;
    mMask = 8'h00; mErr = 1'b0;
    mA0 = 8'h00; mA1 = 8'h00; mB0 = 8'h00; mB1 = 8'h00; mValid = 1'b0;
  endtask

  task automatic modelStep(logic le, logic [2:0] la, logic [7:0] din, logic fe, logic [2:0] fc);
    mA0 = 8'h00; mA1 = 8'h00; mB0 = 8'h00; mB1 = 8'h00; mValid = 1'b0;
    if (fe) begin
      if (fc < 3) begin
        mA0 = aRef(0, int'(fc)); mA1 = aRef(1, int'(fc));
        mB0 = bRef(0, int'(fc)); mB1 = bRef(1, int'(fc));
        mValid = 1'b1;
      end
      if (le) mErr = 1'b1;
      if (int'(fc) == LAST) mMask = 8'h00;
    end else if (le) begin
      mMem[la] = din;
      mMask[la] = 1'b1;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    check({tag, ".a_in0"}, 32'(a_in0), 32'(mA0));
    check({tag, ".a_in1"}, 32'(a_in1), 32'(mA1));
    check({tag, ".b_in0"}, 32'(b_in0), 32'(mB0));
    check({tag, ".b_in1"}, 32'(b_in1), 32'(mB1));
    check({tag, ".feed_valid"}, 32'(feed_valid), 32'(mValid));
    check({tag, ".written_mask"}, 32'(written_mask), 32'(mMask));
    check({tag, ".store_full"}, 32'(store_full), 32'(mMask == 8'hFF));
    check({tag, ".err_overlap"}, 32'(err_overlap), 32'(mErr));
  endtask

  // Drive one cycle's inputs, let the DUT take the edge, then compare against the model.
  task automatic applyStimulus(string tag, logic le, logic [2:0] la, logic [7:0] din,
                               logic fe, logic [2:0] fc);
    load_en = le; load_addr = la; data_in = din; feed_en = fe; feed_cycle = fc;
    @(posedge clk);
    #1;
    modelStep(le, la, din, fe, fc);
    checkOutput(tag);
  endtask

  task automatic idle(string tag);
    applyStimulus(tag, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic feedRun(string tag);
    for (int c = 0; c <= LAST; c++)
      applyStimulus($sformatf("%s.fc%0d", tag, c), 1'b0, 3'd0, 8'h00, 1'b1, 3'(c));
  endtask

  task automatic doReset();
    load_en = 1'b0; feed_en = 1'b0; load_addr = 3'd0; data_in = 8'h00; feed_cycle = 3'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    load_en = 1'b0; load_addr = 3'd0; data_in = 8'h00; feed_en = 1'b0; feed_cycle = 3'd0;
    rst_n = 1'b0;
    modelReset();

    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 3'(i), 8'(i + 1), 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
                 8'((1 << (i + 1)) - 1)};
    tbl[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'd1, 8'd0, 8'd5, 8'd0, 1'b1, 8'hFF};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'd2, 8'd3, 8'd7, 8'd6, 1'b1, 8'hFF};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'd0, 8'd4, 8'd0, 8'd8, 1'b1, 8'hFF};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'hFF};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'hFF};
    tbl[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'h00};

    #12;
    checkOutput("powerOnReset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 15; r++) begin
      string tag = $sformatf("tbl%0d", r);
      applyStimulus(tag, tbl[r].le, tbl[r].la, tbl[r].din, tbl[r].fe, tbl[r].fc);
      check({tag, ".vec_a0"}, 32'(a_in0), 32'(tbl[r].ea0));
      check({tag, ".vec_a1"}, 32'(a_in1), 32'(tbl[r].ea1));
      check({tag, ".vec_b0"}, 32'(b_in0), 32'(tbl[r].eb0));
      check({tag, ".vec_b1"}, 32'(b_in1), 32'(tbl[r].eb1));
      check({tag, ".vec_valid"}, 32'(feed_valid), 32'(tbl[r].ev));
      check({tag, ".vec_mask"}, 32'(written_mask), 32'(tbl[r].emask));
      if (r == 7) check("tbl.store_full", 32'(store_full), 32'd1);
    end

    // Second load/feed round must show only the new operands.
    for (int i = 0; i < 8; i++) applyStimulus("b2b.load", 1'b1, 3'(i), 8'(9 + i), 1'b0, 3'd0);
    applyStimulus("b2b.fc0", 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    check("b2b.c0", {a_in0, a_in1, b_in0, b_in1}, {8'd9, 8'd0, 8'd13, 8'd0});
    applyStimulus("b2b.fc1", 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
    check("b2b.c1", {a_in0, a_in1, b_in0, b_in1}, {8'd10, 8'd11, 8'd15, 8'd14});
    applyStimulus("b2b.fc2", 1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    check("b2b.c2", {a_in0, a_in1, b_in0, b_in1}, {8'd0, 8'd12, 8'd0, 8'd16});
    for (int c = 3; c <= LAST; c++) applyStimulus("b2b.tail", 1'b0, 3'd0, 8'h00, 1'b1, 3'(c));
    idle("b2b.idle");

    applyStimulus("part.w0", 1'b1, 3'd0, 8'h3C, 1'b0, 3'd0);
    applyStimulus("part.w1", 1'b1, 3'd1, 8'h5A, 1'b0, 3'd0);
    applyStimulus("part.w4", 1'b1, 3'd4, 8'hC3, 1'b0, 3'd0);
    check("part.mask", 32'(written_mask), 32'h13);
    check("part.full", 32'(store_full), 32'd0);
    applyStimulus("part.fc0", 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    check("part.a0", 32'(a_in0), 32'h3C);
    check("part.b0", 32'(b_in0), 32'hC3);
    for (int c = 1; c <= LAST; c++) applyStimulus("part.tail", 1'b0, 3'd0, 8'h00, 1'b1, 3'(c));
    idle("part.idle");

    applyStimulus("ovw.w1", 1'b1, 3'd7, 8'h11, 1'b0, 3'd0);
    applyStimulus("ovw.w2", 1'b1, 3'd7, 8'h22, 1'b0, 3'd0);
    check("ovw.mask7", 32'(written_mask[7]), 32'd1);
    applyStimulus("ovw.fc0", 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    applyStimulus("ovw.fc1", 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
    applyStimulus("ovw.fc2", 1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    check("ovw.b_in1", 32'(b_in1), 32'h22);
    for (int c = 3; c <= LAST; c++) applyStimulus("ovw.tail", 1'b0, 3'd0, 8'h00, 1'b1, 3'(c));
    idle("ovw.idle");

    for (int i = 0; i < 8; i++) applyStimulus("ovl.load", 1'b1, 3'(i), 8'(8'h40 + i), 1'b0, 3'd0);
    applyStimulus("ovl.fc0", 1'b1, 3'd2, 8'hAA, 1'b1, 3'd0);
    check("ovl.err", 32'(err_overlap), 32'd1);
    applyStimulus("ovl.fc1", 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
    check("ovl.mem2", 32'(a_in1), 32'h42);
    check("ovl.maskKept", 32'(written_mask), 32'hFF);
    idle("ovl.idle");
    check("ovl.errSticky", 32'(err_overlap), 32'd1);

    // Asynchronous reset lands between edges while feed_cycle=1 is presented.
    for (int i = 0; i < 8; i++) applyStimulus("ar.load", 1'b1, 3'(i), 8'(8'h70 + i), 1'b0, 3'd0);
    applyStimulus("ar.fc0", 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    feed_cycle = 3'd1;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncReset");
    check("ar.err", 32'(err_overlap), 32'd0);
    feed_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    feedRun("ar.postFeed");
    idle("ar.idle");

    for (int n = 0; n < 400; n++) begin
      logic fe;
      if (n % 100 == 99) doReset();
      fe = ($urandom_range(0, 2) == 0);
      applyStimulus("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    8'($urandom), fe, 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/operand_skew_feeder.md
Name: operand_skew_feeder

Overview:
- Responder/datapath end of the matrix-load and feed interface driven by the TPU control unit.
- Captures the 8 operand bytes that arrive from the host during the load phase into an addressed operand store. Store layout: A = 2x2 at addr 0-3, B = 2x2 at addr 4-7.
- During the feed phase, drives the 2x2 systolic MMU edges with the diagonally skewed A-row and B-column streams, indexed by the control unit's cycle count.

Parameters:
- DATA_W, 8, operand width in bits.
- LAST_CYCLE, 5, feed_cycle value on which the feed phase ends and the store is released.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- load_en  input  1  write strobe from control unit (wm_load_mat).
- load_addr  input  3  store address (wm_addr). 0-3 = a00,a01,a10,a11; 4-7 = b00,b01,b10,b11.
- data_in  input  DATA_W  host operand byte.
- feed_en  input  1  feed phase active (feeding_en).
- feed_cycle  input  3  feed cycle index (mmu_cycles).
- a_in0  output  DATA_W  MMU row-0 A input.
- a_in1  output  DATA_W  MMU row-1 A input.
- b_in0  output  DATA_W  MMU col-0 B input.
- b_in1  output  DATA_W  MMU col-1 B input.
- feed_valid  output  1  operand outputs carry schedule data this cycle.
- written_mask  output  8  per-address written flags.
- store_full  output  1  written_mask == 8'hFF.
- err_overlap  output  1  sticky; a write was attempted during feed.

Behaviour:
- Reset (async, rst_n low):
  - All store entries = 0.
  - a_in0/a_in1/b_in0/b_in1 = 0, feed_valid = 0, written_mask = 0, err_overlap = 0.
  - Reset mid-load or mid-feed discards all contents. No partial state survives.
- Write:
  - At a posedge with load_en=1 and feed_en=0: mem[load_addr] <= data_in, and written_mask[load_addr] <= 1.
  - Rewriting the same address overwrites the entry; the mask bit stays 1.
  - store_full is combinational from written_mask.
- Simultaneous load_en=1 and feed_en=1: feed has priority. The write is dropped, the store and mask are unchanged, and err_overlap <= 1. err_overlap clears only on reset.
- Feed schedule: registered, with 1-cycle latency. At a posedge with feed_en=1, outputs are loaded according to feed_cycle:
  - 0: a_in0=a00, a_in1=0, b_in0=b00, b_in1=0.
  - 1: a_in0=a01, a_in1=a10, b_in0=b10, b_in1=b01.
  - 2: a_in0=0, a_in1=a11, b_in0=0, b_in1=b11.
  - 3..7: all four outputs = 0.
  - feed_valid <= 1 for feed_cycle 0..2; otherwise feed_valid <= 0.
- Any posedge with feed_en=0: all four operand outputs <= 0 and feed_valid <= 0, so zeros flush the array.
- End of feed: at a posedge with feed_en=1 and feed_cycle==LAST_CYCLE, written_mask <= 0. Store contents are retained but treated as stale.
- No store_full gating: feeding with store_full=0 still drives the current (possibly stale or zero) contents.
- feed_cycle values above LAST_CYCLE behave as 3..7 (zero outputs); the mask is not cleared again.
- Arithmetic: pure data movement. No width growth; outputs are DATA_W wide.

Decomposition:
- Shared package tpu_pkg:
  - DATA_W.
  - Address constants ADDR_A00..ADDR_B11 (0-7).
  - FEED_LAST_CYCLE = 5.
  - Control-unit state encodings (IDLE/LOAD_MATS/FEED), so the control unit and this block agree.
- One sub-module: operand_store. Holds the 8 x DATA_W register file, written_mask, and overlap detection.
- Top level holds the skew schedule mux and the output registers.

Test Plan:
- Load then feed: write 1,2,3,4 to addr 0-3 and 5,6,7,8 to addr 4-7. Check store_full=1, then run feed_cycle 0..5. Outputs one cycle later:
  - (a0,a1,b0,b1) = (1,0,5,0), then (2,3,7,6), then (0,4,0,8), then (0,0,0,0) x3.
  - feed_valid high for exactly 3 cycles.
  - written_mask=0 after cycle 5.
- Partial load: write addr 0,1,4 only. Check written_mask=8'h13 and store_full=0. Feed cycle 0 gives a_in0=first byte, b_in0=third byte.
- Overlap: hold feed_en=1, pulse load_en with addr 2, data 8'hAA. Check mem[2] unchanged, err_overlap=1, and err_overlap stays 1 after feed_en drops.
- Overwrite: write 8'h11 then 8'h22 to addr 7, then feed. b_in1=8'h22 at feed cycle 2; written_mask[7]=1 before feed.
- Async reset: assert rst_n low mid-feed between clock edges (feed_cycle=1). Check immediately: outputs=0, feed_valid=0, written_mask=0, err_overlap=0. After release, a feed with no reload outputs all zeros.
- Back-to-back: load/feed run twice with different data (second run A=9..12, B=13..16). Second-run outputs reflect only the new data: (9,0,13,0), then (10,11,15,14), then (0,12,0,16).
